irq_priority_unit: RTL and testbench
====================================

# irq_priority_unit

Holds the interrupt request, in-service and mask registers of the 8259-style controller and resolves which request is serviced next. It sits between the external IR pins and the control logic. It raises `int_req` toward the control logic, and it tracks the two-pulse INTA acknowledge sequence. On the second pulse it produces the interrupt vector, which the data bus buffer drives out.

## Interface
- `VECTOR_BASE_RST`, default `5'b00001`: reset value of the vector base, T7–T3.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `ir`  in  8  raw request lines IR7..IR0, synchronous to `clk`.
- `ltim`  in  1  trigger mode: 1 = level-triggered, 0 = edge-triggered.
- `imr_wr`  in  1  one-cycle strobe that loads `imr_data` into IMR.
- `imr_data`  in  8  new mask value.
- `base_wr`  in  1  one-cycle strobe that loads `base_data` into the vector base.
- `base_data`  in  5  vector base, T7–T3.
- `eoi_ns`  in  1  non-specific EOI pulse.
- `eoi_sp`  in  1  specific EOI pulse.
- `eoi_level`  in  3  IR level cleared by `eoi_sp`.
- `rotate_en`  in  1  rotate priority on non-specific EOI.
- `auto_eoi`  in  1  clear the ISR bit automatically at the end of the second INTA.
- `inta_n`  in  1  active-low acknowledge strobe.
- `int_req`  out  1  interrupt request to the control logic.
- `vector`  out  8  `{base, level}`.
- `vector_valid`  out  1  vector is valid to be driven on the bus.
- `irr`, `isr`, `imr`  out  8 each  register contents, for status reads.

## Operation
- Sampling: `ir_q` holds `ir` registered on every clock.
  - Edge mode: an IRR bit sets on `ir & ~ir_q`. It clears when `ir` is low or when that level is acknowledged.
  - Level mode: each IRR bit equals `ir_q`, except the acknowledged bit, which is forced to 0 for that cycle.
- Candidates: `cand = irr & ~imr`.
- Priority order: starts one level above the pointer `lp`, so `lp+1` is highest priority and `lp` is lowest. Level arithmetic is 3-bit modulo 8.
- Fully nested rule: `int_req` is set when the highest-priority candidate is strictly higher than the highest-priority ISR bit, or when `isr == 0`.
- FSM states:
  - IDLE: on a detected `inta_n` fall, go to ACK1.
  - ACK1: on entry, latch `lvl` as the highest candidate. Set `isr[lvl]` and clear `irr[lvl]`. On the next `inta_n` fall, go to ACK2.
  - ACK2: assert `vector_valid` while `inta_n` is low. On the `inta_n` rise, clear `isr[lvl]` if `auto_eoi` is set; also rotate (`lp <= lvl`) if `rotate_en` is set. Then go to IDLE.
- Spurious acknowledge: if `cand == 0` at the first fall, set `lvl = 7` and leave ISR unchanged (spurious IR7). The FSM still walks ACK1 → ACK2.
- `eoi_ns` clears the highest-priority set ISR bit. If `rotate_en` is set, `lp` becomes that level. With `isr == 0`, `eoi_ns` has no effect.
- `eoi_sp` clears `isr[eoi_level]`. `lp` is not changed.
- Fall detection: `inta_q` holds `inta_n` registered. A fall is `inta_q & ~inta_n`; a rise is `~inta_q & inta_n`.

## Timing
- Reset values: `irr = isr = imr = 0`, `lp = 7` (IR0 highest), base = `VECTOR_BASE_RST`, state IDLE, `int_req = 0`, `vector = 0`, `vector_valid = 0`, `ir_q = 0`, `inta_q = 1`.
- Reset asserted mid-sequence returns every register to its reset value on the next clock.
- A rise on `ir` sets IRR at edge N+1 and `int_req` at edge N+2.
- On the edge that detects the first fall, ISR and IRR update and `int_req` clears. `int_req` is re-evaluated from IDLE on the cycle after the sequence returns.
- `vector` and `vector_valid` are registered. They become valid at the edge after the second fall is detected and drop at the edge after `inta_n` rises.
- `imr_wr` affects resolution from the next cycle onward. A write during ACK1 or ACK2 does not change `lvl`.
- EOI and the first-fall ISR set in the same cycle: apply the EOI clear first, then the set. An EOI targeting `lvl` in the same cycle leaves `isr[lvl]` set.
- `eoi_ns` and `eoi_sp` together: apply `eoi_sp` only.
- A new edge on an already-pending IR bit is ignored (IRR is already 1).

## Structure
- Package `pic_pkg` holds:
  - the state enum `pic_ack_e` (IDLE, ACK1, ACK2);
  - `pic_lvl_t` (3 bits);
  - the function `highest_bit(vec, lp)` returning a valid flag and a level.
- Sub-module `priority_resolver` is purely combinational. It takes `cand`, `isr` and `lp`, and outputs `cand_lvl`, `cand_vld`, `isr_lvl`, `isr_vld` and `req`.
- The FSM, the registers and the EOI logic live in the top module.

## Test plan
- Edge mode, `imr = 0`: pulse `ir[3]` → `int_req` = 1 two cycles later. Two INTA pulses → `isr = 8'h08`, `irr = 0`, `vector = 8'h0B` with base 1.
- Nesting: IR5 in service, then raise IR2 → `int_req` = 1. Then raise IR6 only → `int_req` stays 0 until `eoi_ns`, after which `isr = 0` and `int_req` = 1.
- Masking: `imr = 8'h10`, raise `ir[4]` → `irr = 8'h10` with `int_req` = 0. Write `imr = 0` → `int_req` = 1 the following cycles.
- Rotation: `rotate_en = 1`, service IR0, issue `eoi_ns` → `lp = 0`. Then raise IR0 and IR1 together → IR1 acknowledged first, `vector` low bits = 3'd1.
- Spurious: raise `ir[2]` in level mode, drop it before the first INTA fall → `isr` unchanged, `vector` low bits = 3'd7.
- Reset applied during ACK2 → all outputs return to reset values on the next edge; `vector_valid` = 0.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared types and helpers for the 8259-style interrupt priority unit.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package pic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK1 = 2'd1,
        ACK2 = 2'd2
    } pic_ack_e;

    typedef logic [2:0] pic_lvl_t;

    typedef struct packed {
        logic     vld;
        pic_lvl_t lvl;
    } pic_hit_t;

    // Level reported when an acknowledge finds no unmasked request.
    localparam pic_lvl_t SPURIOUS_LVL = 3'd7;
    // Reset pointer: lowest priority at IR7, so IR0 is the highest.
    localparam pic_lvl_t LP_RST       = 3'd7;

    // Highest-priority set bit of vec, with lp+1 highest and lp lowest.
    function automatic pic_hit_t highest_bit(input logic [7:0] vec, input pic_lvl_t lp);
        pic_hit_t hit;
        pic_lvl_t idx;
        hit = '0;
        for (int i = 1; i <= 8; i++) begin
            idx = lp + pic_lvl_t'(i);
            if (!hit.vld && vec[idx]) begin
                hit.vld = 1'b1;
                hit.lvl = idx;
            end
        end
        return hit;
    endfunction

    // Priority rank of a level: 0 is highest (lp+1), 7 is lowest (lp).
    function automatic pic_lvl_t prio_rank(input pic_lvl_t lvl, input pic_lvl_t lp);
        return lvl - lp - 3'd1;
    endfunction

endpackage

// File: rtl/priority_resolver.sv
// Picks the highest-priority candidate and in-service level and decides int_req.
// Latency: purely combinational.
// Backpressure: none.
// Ports: cand/isr (8b vectors), lp (lowest-priority pointer) in;
//        cand_lvl/cand_vld, isr_lvl/isr_vld, req out.
module priority_resolver
    import pic_pkg::*;
(
    input  logic [7:0] cand,
    input  logic [7:0] isr,
    input  pic_lvl_t   lp,
    output pic_lvl_t   cand_lvl,
    output logic       cand_vld,
    output pic_lvl_t   isr_lvl,
    output logic       isr_vld,
    output logic       req
);

    pic_hit_t cand_hit;
    pic_hit_t isr_hit;

    always_comb begin
        cand_hit = highest_bit(cand, lp);
        isr_hit  = highest_bit(isr, lp);
        cand_vld = cand_hit.vld;
        cand_lvl = cand_hit.lvl;
        isr_vld  = isr_hit.vld;
        isr_lvl  = isr_hit.lvl;
        // Fully nested: only a strictly higher level may interrupt service.
        req      = cand_hit.vld &&
                   (!isr_hit.vld || (prio_rank(cand_hit.lvl, lp) < prio_rank(isr_hit.lvl, lp)));
    end

endmodule

// File: rtl/irq_priority_unit.sv
// IRR/ISR/IMR registers, nested priority resolution and two-pulse INTA vector sequence.
// Latency: IR rise -> IRR +1 clk, int_req +2 clk; vector valid on the edge detecting the 2nd INTA fall.
// Backpressure: none; inta_n paces the acknowledge sequence, IR lines are sampled every clock.
// Ports: clk, reset_n (sync, active low); ir, ltim, imr_wr/imr_data, base_wr/base_data,
//        eoi_ns, eoi_sp/eoi_level, rotate_en, auto_eoi, inta_n in;
//        int_req, vector, vector_valid, irr/isr/imr status out.
module irq_priority_unit
    import pic_pkg::*;
#(
    parameter logic [4:0] VECTOR_BASE_RST = 5'b00001
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] ir,
    input  logic       ltim,
    input  logic       imr_wr,
    input  logic [7:0] imr_data,
    input  logic       base_wr,
    input  logic [4:0] base_data,
    input  logic       eoi_ns,
    input  logic       eoi_sp,
    input  logic [2:0] eoi_level,
    input  logic       rotate_en,
    input  logic       auto_eoi,
    input  logic       inta_n,
    output logic       int_req,
    output logic [7:0] vector,
    output logic       vector_valid,
    output logic [7:0] irr,
    output logic [7:0] isr,
    output logic [7:0] imr
);

    pic_ack_e   state;
    pic_ack_e   state_nxt;
    logic [7:0] ir_q;
    logic       inta_q;
    pic_lvl_t   lp;
    pic_lvl_t   lp_nxt;
    pic_lvl_t   lvl;
    logic       spur;
    logic [4:0] base;

    logic       inta_fall;
    logic       inta_rise;
    logic [7:0] cand;
    pic_lvl_t   cand_lvl;
    pic_lvl_t   isr_lvl;
    logic       cand_vld;
    logic       isr_vld;
    logic       req;

    logic       ack_start;
    logic       ack_vec;
    logic       ack_end;
    logic [7:0] ack_mask;
    logic [7:0] eoi_clr;
    logic [7:0] irr_nxt;
    logic [7:0] isr_nxt;

    assign inta_fall = inta_q & ~inta_n;
    assign inta_rise = ~inta_q & inta_n;
    assign cand      = irr & ~imr;

    priority_resolver u_resolver (
        .cand     (cand),
        .isr      (isr),
        .lp       (lp),
        .cand_lvl (cand_lvl),
        .cand_vld (cand_vld),
        .isr_lvl  (isr_lvl),
        .isr_vld  (isr_vld),
        .req      (req)
    );

    // Acknowledge sequencer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ack_start = 1'b0;
        ack_vec   = 1'b0;
        ack_end   = 1'b0;
        case (state)
            IDLE: begin
                if (inta_fall) begin
                    state_nxt = ACK1;
                    ack_start = 1'b1;
                end
            end
            ACK1: begin
                if (inta_fall) begin
                    state_nxt = ACK2;
                    ack_vec   = 1'b1;
                end
            end
            ACK2: begin
                if (inta_rise) begin
                    state_nxt = IDLE;
                    ack_end   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Register next values. EOI clears are built first and the first-fall
    // set is OR-ed in afterwards, so an EOI aimed at the level being
    // acknowledged in the same cycle cannot undo the new in-service bit.
    always_comb begin
        ack_mask = '0;
        if (ack_start && cand_vld) begin
            ack_mask[cand_lvl] = 1'b1;
        end

        eoi_clr = '0;
        lp_nxt  = lp;
        if (eoi_sp) begin
            eoi_clr[eoi_level] = 1'b1;
        end else if (eoi_ns && isr_vld) begin
            eoi_clr[isr_lvl] = 1'b1;
            if (rotate_en) begin
                lp_nxt = isr_lvl;
            end
        end
        // A spurious acknowledge never touched ISR, so its end neither clears nor rotates.
        if (ack_end && !spur) begin
            if (auto_eoi) begin
                eoi_clr[lvl] = 1'b1;
            end
            if (rotate_en) begin
                lp_nxt = lvl;
            end
        end

        isr_nxt = (isr & ~eoi_clr) | ack_mask;

        if (ltim) begin
            irr_nxt = ir & ~ack_mask;
        end else begin
            // Edge requests latch on a rising edge and hold only while the line stays high.
            irr_nxt = (irr | (ir & ~ir_q)) & ir & ~ack_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ir_q         <= '0;
            inta_q       <= 1'b1;
            irr          <= '0;
            isr          <= '0;
            imr          <= '0;
            lp           <= LP_RST;
            lvl          <= '0;
            spur         <= 1'b0;
            base         <= VECTOR_BASE_RST;
            int_req      <= 1'b0;
            vector       <= '0;
            vector_valid <= 1'b0;
        end else begin
            ir_q   <= ir;
            inta_q <= inta_n;
            irr    <= irr_nxt;
            isr    <= isr_nxt;
            lp     <= lp_nxt;
            if (imr_wr) begin
                imr <= imr_data;
            end
            if (base_wr) begin
                base <= base_data;
            end
            // Request is held low for the whole acknowledge sequence.
            int_req <= (state == IDLE) && !inta_fall && req;
            if (ack_start) begin
                lvl  <= cand_vld ? cand_lvl : SPURIOUS_LVL;
                spur <= !cand_vld;
            end
            if (ack_vec) begin
                vector       <= {base, lvl};
                vector_valid <= 1'b1;
            end else if (ack_end) begin
                vector       <= '0;
                vector_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_irq_priority_unit.sv
// Bench for irq_priority_unit: directed scenarios plus a randomized run against a reference model.
// Latency: not applicable.
// Backpressure: not applicable.
module tb_irq_priority_unit;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] ir;
    logic       ltim;
    logic       imr_wr;
    logic [7:0] imr_data;
    logic       base_wr;
    logic [4:0] base_data;
    logic       eoi_ns;
    logic       eoi_sp;
    logic [2:0] eoi_level;
    logic       rotate_en;
    logic       auto_eoi;
    logic       inta_n;
    logic       int_req;
    logic [7:0] vector;
    logic       vector_valid;
    logic [7:0] irr;
    logic [7:0] isr;
    logic [7:0] imr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    irq_priority_unit dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ir           (ir),
        .ltim         (ltim),
        .imr_wr       (imr_wr),
        .imr_data     (imr_data),
        .base_wr      (base_wr),
        .base_data    (base_data),
        .eoi_ns       (eoi_ns),
        .eoi_sp       (eoi_sp),
        .eoi_level    (eoi_level),
        .rotate_en    (rotate_en),
        .auto_eoi     (auto_eoi),
        .inta_n       (inta_n),
        .int_req      (int_req),
        .vector       (vector),
        .vector_valid (vector_valid),
        .irr          (irr),
        .isr          (isr),
        .imr          (imr)
    );

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_defaults();
        ir = '0; ltim = 1'b0; imr_wr = 1'b0; imr_data = '0; base_wr = 1'b0; base_data = '0;
        eoi_ns = 1'b0; eoi_sp = 1'b0; eoi_level = '0; rotate_en = 1'b0; auto_eoi = 1'b0; inta_n = 1'b1;
    endtask

    task automatic do_reset();
        drive_defaults();
        reset_n = 1'b0;
        cyc(2);
        reset_n = 1'b1;
    endtask

    task automatic inta_pulse();
        inta_n = 1'b0;
        cyc(1);
        inta_n = 1'b1;
        cyc(1);
    endtask

    // Reference helpers: priority search by modular arithmetic on level numbers.
    function automatic int top_of(input bit [7:0] v, input int lp);
        for (int k = 1; k <= 8; k++) begin
            if (v[(lp + k) % 8]) return (lp + k) % 8;
        end
        return -1;
    endfunction

    function automatic int rank_of(input int lvl, input int lp);
        return (lvl - lp + 7) % 8;
    endfunction

    task automatic test_reset();
        drive_defaults();
        ir = 8'hFF;
        reset_n = 1'b0;
        cyc(2);
        n_cmp++; if (irr !== 8'h00) begin n_bad++; $display("FAIL reset_irr: got %h want 00", irr); end
        n_cmp++; if (isr !== 8'h00) begin n_bad++; $display("FAIL reset_isr: got %h want 00", isr); end
        n_cmp++; if (imr !== 8'h00) begin n_bad++; $display("FAIL reset_imr: got %h want 00", imr); end
        n_cmp++; if (int_req !== 1'b0) begin n_bad++; $display("FAIL reset_int_req: got %b want 0", int_req); end
        n_cmp++; if (vector !== 8'h00) begin n_bad++; $display("FAIL reset_vector: got %h want 00", vector); end
        n_cmp++; if (vector_valid !== 1'b0) begin n_bad++; $display("FAIL reset_vv: got %b want 0", vector_valid); end
        ir = '0;
        reset_n = 1'b1;
        cyc(1);
    endtask

    task automatic test_edge_ack();
        do_reset();
        ir = 8'h08;
        cyc(1);
        n_cmp++; if (irr !== 8'h08) begin n_bad++; $display("FAIL edge_irr_set: got %h want 08", irr); end
        n_cmp++; if (int_req !== 1'b0) begin n_bad++; $display("FAIL edge_int_req_early: got %b want 0", int_req); end
        cyc(1);
        n_cmp++; if (int_req !== 1'b1) begin n_bad++; $display("FAIL edge_int_req: got %b want 1", int_req); end
        inta_n = 1'b0;
        cyc(1);
        n_cmp++; if (isr !== 8'h08) begin n_bad++; $display("FAIL edge_isr_ack1: got %h want 08", isr); end
        n_cmp++; if (irr !== 8'h00) begin n_bad++; $display("FAIL edge_irr_ack1: got %h want 00", irr); end
        n_cmp++; if (int_req !== 1'b0) begin n_bad++; $display("FAIL edge_int_req_ack1: got %b want 0", int_req); end
        inta_n = 1'b1;
        cyc(1);
        inta_n = 1'b0;
        cyc(1);
        n_cmp++; if (vector !== 8'h0B) begin n_bad++; $display("FAIL edge_vector: got %h want 0b", vector); end
        n_cmp++; if (vector_valid !== 1'b1) begin n_bad++; $display("FAIL edge_vv: got %b want 1", vector_valid); end
        inta_n = 1'b1;
        cyc(1);
        n_cmp++; if (vector_valid !== 1'b0) begin n_bad++; $display("FAIL edge_vv_drop: got %b want 0", vector_valid); end
        n_cmp++; if (isr !== 8'h08) begin n_bad++; $display("FAIL edge_isr_hold: got %h want 08", isr); end
        ir = '0;
        eoi_ns = 1'b1;
        cyc(1);
        eoi_ns = 1'b0;
        n_cmp++; if (isr !== 8'h00) begin n_bad++; $display("FAIL edge_eoi_ns: got %h want 00", isr); end
    endtask

    task automatic test_nesting();
        do_reset();
        ir = 8'h20;
        cyc(2);
        inta_pulse();
        inta_pulse();
        n_cmp++; if (isr !== 8'h20) begin n_bad++; $display("FAIL nest_isr5: got %h want 20", isr); end
        ir = 8'h04;
        cyc(2);
        n_cmp++; if (int_req !== 1'b1) begin n_bad++; $display("FAIL nest_ir2_req: got %b want 1", int_req); end
        ir = 8'h40;
        cyc(3);
        n_cmp++; if (int_req !== 1'b0) begin n_bad++; $display("FAIL nest_ir6_blocked: got %b want 0", int_req); end
        n_cmp++; if (irr !== 8'h40) begin n_bad++; $display("FAIL nest_irr6: got %h want 40", irr); end
        eoi_ns = 1'b1;
        cyc(1);
        eoi_ns = 1'b0;
        n_cmp++; if (isr !== 8'h00) begin n_bad++; $display("FAIL nest_eoi_isr: got %h want 00", isr); end
        cyc(1);
        n_cmp++; if (int_req !== 1'b1) begin n_bad++; $display("FAIL nest_ir6_req: got %b want 1", int_req); end
    endtask

    task automatic test_mask();
        do_reset();
        imr_data = 8'h10;
        imr_wr = 1'b1;
        cyc(1);
        imr_wr = 1'b0;
        n_cmp++; if (imr !== 8'h10) begin n_bad++; $display("FAIL mask_imr: got %h want 10", imr); end
        ir = 8'h10;
        cyc(3);
        n_cmp++; if (irr !== 8'h10) begin n_bad++; $display("FAIL mask_irr: got %h want 10", irr); end
        n_cmp++; if (int_req !== 1'b0) begin n_bad++; $display("FAIL mask_req_off: got %b want 0", int_req); end
        imr_data = 8'h00;
        imr_wr = 1'b1;
        cyc(1);
        imr_wr = 1'b0;
        cyc(1);
        n_cmp++; if (int_req !== 1'b1) begin n_bad++; $display("FAIL mask_req_on: got %b want 1", int_req); end
    endtask

    task automatic test_rotation();
        do_reset();
        rotate_en = 1'b1;
        ir = 8'h01;
        cyc(2);
        inta_pulse();
        inta_pulse();
        n_cmp++; if (isr !== 8'h01) begin n_bad++; $display("FAIL rot_isr0: got %h want 01", isr); end
        ir = 8'h00;
        eoi_ns = 1'b1;
        cyc(1);
        eoi_ns = 1'b0;
        n_cmp++; if (isr !== 8'h00) begin n_bad++; $display("FAIL rot_eoi: got %h want 00", isr); end
        ir = 8'h03;
        cyc(2);
        n_cmp++; if (int_req !== 1'b1) begin n_bad++; $display("FAIL rot_req: got %b want 1", int_req); end
        inta_n = 1'b0;
        cyc(1);
        n_cmp++; if (isr !== 8'h02) begin n_bad++; $display("FAIL rot_isr1: got %h want 02", isr); end
        n_cmp++; if (irr !== 8'h01) begin n_bad++; $display("FAIL rot_irr0_left: got %h want 01", irr); end
        inta_n = 1'b1;
        cyc(1);
        inta_n = 1'b0;
        cyc(1);
        n_cmp++; if (vector !== 8'h09) begin n_bad++; $display("FAIL rot_vector: got %h want 09", vector); end
        inta_n = 1'b1;
        cyc(1);
    endtask

    task automatic test_spurious();
        do_reset();
        ltim = 1'b1;
        ir = 8'h04;
        cyc(1);
        n_cmp++; if (irr !== 8'h04) begin n_bad++; $display("FAIL spur_irr_level: got %h want 04", irr); end
        cyc(1);
        n_cmp++; if (int_req !== 1'b1) begin n_bad++; $display("FAIL spur_req: got %b want 1", int_req); end
        ir = 8'h00;
        cyc(1);
        inta_n = 1'b0;
        cyc(1);
        n_cmp++; if (isr !== 8'h00) begin n_bad++; $display("FAIL spur_isr_ack1: got %h want 00", isr); end
        inta_n = 1'b1;
        cyc(1);
        inta_n = 1'b0;
        cyc(1);
        n_cmp++; if (vector !== 8'h0F) begin n_bad++; $display("FAIL spur_vector: got %h want 0f", vector); end
        n_cmp++; if (vector_valid !== 1'b1) begin n_bad++; $display("FAIL spur_vv: got %b want 1", vector_valid); end
        inta_n = 1'b1;
        cyc(1);
        n_cmp++; if (isr !== 8'h00) begin n_bad++; $display("FAIL spur_isr_end: got %h want 00", isr); end
    endtask

    task automatic test_eoi_collision();
        do_reset();
        ir = 8'h10;
        cyc(2);
        inta_pulse();
        inta_pulse();
        ir = 8'h02;
        cyc(2);
        inta_n = 1'b0;
        eoi_sp = 1'b1;
        eoi_level = 3'd1;
        cyc(1);
        eoi_sp = 1'b0;
        n_cmp++; if (isr !== 8'h12) begin n_bad++; $display("FAIL coll_eoi_vs_set: got %h want 12", isr); end
        inta_n = 1'b1;
        cyc(1);
        inta_n = 1'b0;
        cyc(1);
        n_cmp++; if (vector !== 8'h09) begin n_bad++; $display("FAIL coll_vector: got %h want 09", vector); end
        inta_n = 1'b1;
        ir = 8'h00;
        cyc(1);
        eoi_ns = 1'b1;
        eoi_sp = 1'b1;
        eoi_level = 3'd4;
        cyc(1);
        eoi_ns = 1'b0;
        eoi_sp = 1'b0;
        n_cmp++; if (isr !== 8'h02) begin n_bad++; $display("FAIL coll_sp_over_ns: got %h want 02", isr); end
    endtask

    task automatic test_auto_eoi();
        do_reset();
        auto_eoi = 1'b1;
        ir = 8'h80;
        cyc(2);
        inta_n = 1'b0;
        cyc(1);
        n_cmp++; if (isr !== 8'h80) begin n_bad++; $display("FAIL aeoi_isr_set: got %h want 80", isr); end
        inta_n = 1'b1;
        cyc(1);
        inta_pulse();
        n_cmp++; if (isr !== 8'h00) begin n_bad++; $display("FAIL aeoi_isr_clear: got %h want 00", isr); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        imr_data = 8'h80;
        imr_wr = 1'b1;
        cyc(1);
        imr_wr = 1'b0;
        ir = 8'h01;
        cyc(2);
        inta_n = 1'b0;
        cyc(1);
        inta_n = 1'b1;
        cyc(1);
        inta_n = 1'b0;
        cyc(1);
        n_cmp++; if (vector_valid !== 1'b1) begin n_bad++; $display("FAIL rmid_in_ack2: got %b want 1", vector_valid); end
        reset_n = 1'b0;
        inta_n = 1'b1;
        cyc(1);
        n_cmp++; if (vector_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_vv: got %b want 0", vector_valid); end
        n_cmp++; if (vector !== 8'h00) begin n_bad++; $display("FAIL rmid_vector: got %h want 00", vector); end
        n_cmp++; if (isr !== 8'h00) begin n_bad++; $display("FAIL rmid_isr: got %h want 00", isr); end
        n_cmp++; if (irr !== 8'h00) begin n_bad++; $display("FAIL rmid_irr: got %h want 00", irr); end
        n_cmp++; if (imr !== 8'h00) begin n_bad++; $display("FAIL rmid_imr: got %h want 00", imr); end
        n_cmp++; if (int_req !== 1'b0) begin n_bad++; $display("FAIL rmid_int_req: got %b want 0", int_req); end
        ir = 8'h00;
        reset_n = 1'b1;
        cyc(1);
    endtask

    task automatic test_random();
        bit [7:0] m_irr, m_isr, m_imr, m_irq, m_vec;
        bit [7:0] n_irr, n_isr, n_imr, n_vec;
        int       m_lp, m_lvl, m_ph, m_base, n_lp, n_lvl, n_ph, n_base, c, s, ack;
        bit       m_spur, m_inta_q, m_int_req, m_vv, n_spur, n_int_req, n_vv, fall, rise, req;
        do_reset();
        m_irr = '0; m_isr = '0; m_imr = '0; m_irq = '0; m_vec = '0;
        m_lp = 7; m_lvl = 0; m_ph = 0; m_base = 1;
        m_spur = 1'b0; m_inta_q = 1'b1; m_int_req = 1'b0; m_vv = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(0, 3) == 0) ir = 8'($urandom);
            if ($urandom_range(0, 199) == 0) ltim = ~ltim;
            if ($urandom_range(0, 2) == 0) inta_n = ~inta_n;
            imr_wr    = ($urandom_range(0, 15) == 0);
            imr_data  = 8'($urandom) & 8'($urandom);
            base_wr   = ($urandom_range(0, 31) == 0);
            base_data = 5'($urandom);
            eoi_ns    = ($urandom_range(0, 11) == 0);
            eoi_sp    = ($urandom_range(0, 15) == 0);
            eoi_level = 3'($urandom);
            rotate_en = 1'($urandom_range(0, 1));
            auto_eoi  = 1'($urandom_range(0, 1));

            fall = m_inta_q && !inta_n;
            rise = !m_inta_q && inta_n;
            c    = top_of(m_irr & ~m_imr, m_lp);
            s    = top_of(m_isr, m_lp);
            req  = (c >= 0) && ((s < 0) || (rank_of(c, m_lp) < rank_of(s, m_lp)));
            n_isr = m_isr; n_lp = m_lp; n_lvl = m_lvl; n_spur = m_spur; n_ph = m_ph;
            n_vec = m_vec; n_vv = m_vv; ack = -1;
            if (eoi_sp) n_isr[eoi_level] = 1'b0;
            else if (eoi_ns && s >= 0) begin
                n_isr[s] = 1'b0;
                if (rotate_en) n_lp = s;
            end
            if (m_ph == 0 && fall) begin
                n_ph = 1;
                if (c >= 0) begin ack = c; n_lvl = c; n_spur = 1'b0; n_isr[c] = 1'b1; end
                else begin n_lvl = 7; n_spur = 1'b1; end
            end else if (m_ph == 1 && fall) begin
                n_ph = 2; n_vec = 8'(m_base * 8 + m_lvl); n_vv = 1'b1;
            end else if (m_ph == 2 && rise) begin
                n_ph = 0; n_vec = '0; n_vv = 1'b0;
                if (!m_spur) begin
                    if (auto_eoi) n_isr[m_lvl] = 1'b0;
                    if (rotate_en) n_lp = m_lvl;
                end
            end
            for (int b = 0; b < 8; b++) begin
                if (ltim) n_irr[b] = ir[b];
                else      n_irr[b] = (m_irr[b] || (ir[b] && !m_irq[b])) && ir[b];
                if (b == ack) n_irr[b] = 1'b0;
            end
            n_int_req = (m_ph == 0) && !fall && req;
            n_imr  = imr_wr ? imr_data : m_imr;
            n_base = base_wr ? int'(base_data) : m_base;

            cyc(1);

            m_irr = n_irr; m_isr = n_isr; m_imr = n_imr; m_irq = ir; m_inta_q = inta_n;
            m_lp = n_lp; m_lvl = n_lvl; m_spur = n_spur; m_ph = n_ph; m_base = n_base;
            m_vec = n_vec; m_vv = n_vv; m_int_req = n_int_req;

            n_cmp++; if (irr !== m_irr) begin n_bad++; $display("FAIL rand_irr t=%0d: got %h want %h", t, irr, m_irr); end
            n_cmp++; if (isr !== m_isr) begin n_bad++; $display("FAIL rand_isr t=%0d: got %h want %h", t, isr, m_isr); end
            n_cmp++; if (imr !== m_imr) begin n_bad++; $display("FAIL rand_imr t=%0d: got %h want %h", t, imr, m_imr); end
            n_cmp++; if (int_req !== m_int_req) begin n_bad++; $display("FAIL rand_int_req t=%0d: got %b want %b", t, int_req, m_int_req); end
            n_cmp++; if (vector !== m_vec) begin n_bad++; $display("FAIL rand_vector t=%0d: got %h want %h", t, vector, m_vec); end
            n_cmp++; if (vector_valid !== m_vv) begin n_bad++; $display("FAIL rand_vv t=%0d: got %b want %b", t, vector_valid, m_vv); end
        end
    endtask

    initial begin
        drive_defaults();
        reset_n = 1'b0;
        test_reset();
        test_edge_ack();
        test_nesting();
        test_mask();
        test_rotation();
        test_spurious();
        test_eoi_collision();
        test_auto_eoi();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
